// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, hazard/redirect controls, IF/ID outputs and perf counters.
// master = fetch stage side, slave = surrounding core / memory side.
interface fetch_stage_if #(
    parameter int PC_W = 16
) ();
    logic [PC_W-1:0] imem_addr;
    logic [PC_W-1:0] imem_data;
    logic            imem_valid;
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] instr_out;
    logic [PC_W-1:0] pc_out;
    logic            valid_out;
    logic            halted;
    logic [15:0]     fetch_cnt;
    logic [15:0]     bubble_cnt;

    modport master (
        output imem_addr,
        input  imem_data,
        input  imem_valid,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output instr_out,
        output pc_out,
        output valid_out,
        output halted,
        output fetch_cnt,
        output bubble_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output imem_valid,
        output stall,
        output redirect,
        output redirect_pc,
        input  instr_out,
        input  pc_out,
        input  valid_out,
        input  halted,
        input  fetch_cnt,
        input  bubble_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; imem word reaches instr_out one edge later, redirect target two edges later.
// stall holds PC, IF/ID and state; HALT parks fetch until a redirect. Perf counters built only with FETCH_PERF_EN.
module fetch_stage #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [PC_W-1:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]      HALT_OP   = 5'b00000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0] pcout_q, pcout_d;
    logic            vld_q, vld_d;
    logic            fetch_inc;
    logic            bubble_inc;
    logic [PC_W-1:0] pc_plus2;
    logic            is_halt;

    assign pc_plus2 = pc_q + PC_W'(2);
    assign is_halt  = (bus.imem_data[PC_W-1 -: 5] == HALT_OP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcout_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            vld_q   <= vld_d;
        end
    end

    // Priority: redirect > stall > halted > missing imem word > normal load.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pcout_d    = pcout_q;
        vld_d      = vld_q;
        fetch_inc  = 1'b0;
        bubble_inc = 1'b0;

        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            instr_d    = NOP_INSTR;
            pcout_d    = '0;
            vld_d      = 1'b0;
            state_d    = ST_RUN;
            bubble_inc = 1'b1;
        end else if (bus.stall) begin
            // Full hold; deliberately not counted as a bubble.
        end else if (state_q == ST_HALTED || !bus.imem_valid) begin
            instr_d    = NOP_INSTR;
            vld_d      = 1'b0;
            bubble_inc = 1'b1;
        end else begin
            instr_d   = bus.imem_data;
            pcout_d   = pc_plus2;
            vld_d     = 1'b1;
            fetch_inc = 1'b1;
            if (is_halt) begin
                // PC parks on the HALT address so imem_addr stays put while halted.
                state_d = ST_HALTED;
            end else begin
                pc_d = pc_plus2;
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.instr_out = instr_q;
    assign bus.pc_out    = pcout_q;
    assign bus.valid_out = vld_q;
    assign bus.halted    = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (fetch_inc && fetch_cnt_q != 16'hFFFF) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (bubble_inc && bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.fetch_cnt  = fetch_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
`else
    logic perf_unused;
    assign perf_unused    = fetch_inc | bubble_inc;
    assign bus.fetch_cnt  = '0;
    assign bus.bubble_cnt = '0;
`endif

endmodule
